systolic_skew_buffer: RTL
=========================

Name: systolic_skew_buffer

Overview:
Parametrised, frame-aware successor to the systolic data-setup skew stage. It accepts one row of LENGTH lane values per beat through a valid/ready handshake and delays each lane by a lane-dependent number of cycles before presenting it to the systolic array edge. It supports run-time skew mode (feeding the array) and deskew mode (realigning array outputs). It drains automatically after the last beat of a frame and flags completion.

Parameters:
WIDTH, 8, bit width of each lane value
LENGTH, 5, number of lanes (>=1); the maximum lane delay is LENGTH-1

Ports:
CLK  in  1  clock; all logic on the rising edge
SYNC_RST  in  1  reset, synchronous, active-low
EN  in  1  global advance enable; 0 = stall the entire block
MODE  in  1  0 = skew (lane i delay d_i = i), 1 = deskew (d_i = LENGTH-1-i); latched on the first accepted beat of a frame
IN_VALID  in  1  input row valid
IN_LAST  in  1  current row is the last row of the frame; qualified by IN_VALID
IN_READY  out  1  block accepts a row this cycle
Inputs  in  WIDTH x [0:LENGTH-1]  input row, unpacked array
Outputs  out  WIDTH x [0:LENGTH-1]  skewed lane outputs, registered
OUT_VALID  out  LENGTH  per-lane valid for Outputs[i]
BUSY  out  1  FSM is not in IDLE
FRAME_DONE  out  1  one-cycle pulse marking the final valid output of a frame

Behaviour:
- Reset: if SYNC_RST==0 at a rising edge, the following clear to 0 and the FSM enters IDLE: all delay stages, Outputs, OUT_VALID, the drain counter, the latched mode, and FRAME_DONE. Reset overrides EN. Reset mid-frame discards all in-flight data; no FRAME_DONE is produced for that frame.
- IN_READY is combinational: SYNC_RST & EN & (state != DRAIN).
- A row is accepted at an edge where IN_VALID & IN_READY is true.
- Timing:
  - Every lane has one output register, so the minimum latency is 1 cycle.
  - A row accepted at edge k appears on Outputs[i] with OUT_VALID[i]=1 after edge k+d_i, counting only edges where EN=1.
  - In skew mode with LENGTH=5, lane 0 appears after edge k and lane 4 after edge k+4.
- Bubbles: on any EN=1 edge with no accepted row (IDLE without valid, STREAM with IN_VALID=0, or DRAIN), zeros with valid=0 enter every lane. Bubbles propagate with the same per-lane delays as data.
- Stall: when EN=0, every register holds its value, including delay stages, Outputs, OUT_VALID, FSM, counter and latched mode. FRAME_DONE is the exception and clears on the next edge regardless of EN.
- FSM states are IDLE, STREAM and DRAIN.
  - IDLE: on accept, latch MODE. Go to STREAM if IN_LAST=0, otherwise to DRAIN.
  - STREAM: on accept with IN_LAST=1, go to DRAIN. MODE is ignored in this state.
  - DRAIN: load the counter with LENGTH-1 on entry. Decrement it on each EN=1 edge. At the EN=1 edge where the counter is 1, go to IDLE and register FRAME_DONE=1.
- Drain timing: FRAME_DONE is high in the same cycle the last row appears on the longest-delay lane (lane LENGTH-1 in skew mode, lane 0 in deskew mode).
- LENGTH==1: an accept with IN_LAST=1 goes directly to IDLE, and FRAME_DONE pulses at that same edge.
- Back-to-back frames: after FRAME_DONE the FSM is in IDLE, so the next frame's first row can be accepted at the following edge. The latched mode can change only between frames, and all lanes are empty at that point.
- The counter width is clog2(LENGTH) and has a minimum of 1 bit.
- No arithmetic is performed on data; lane values pass through unmodified.

Test Plan:
All scenarios use WIDTH=8, LENGTH=5. Edge E0 is the first accept edge.
1. Reset: SYNC_RST=0 for 2 cycles, EN=1, IN_VALID=1, all Inputs=0xFF. Required: Outputs all 0, OUT_VALID=0, IN_READY=0, BUSY=0, FRAME_DONE=0.
2. Skew: MODE=0, rows {1,2,3,4,5}, {6,7,8,9,10}, {11,12,13,14,15}, IN_LAST on row 3 at E2. Required: lane 0 shows 1, 6, 11 after E0, E1, E2. Lane 4 shows 5, 10, 15 after E4, E5, E6. FRAME_DONE is high only in the cycle after E6, with Outputs[4]=15. BUSY is low after E6.
3. Deskew: MODE=1, same rows. Required: lane 4 shows 5, 10, 15 after E0, E1, E2. Lane 0 shows 1, 6, 11 after E4, E5, E6. FRAME_DONE is coincident with Outputs[0]=11.
4. Stall in drain: scenario 2 with EN=0 for 3 cycles after E3. Required: Outputs, OUT_VALID and the counter are frozen and IN_READY=0 during the stall. FRAME_DONE is delayed by exactly 3 cycles.
5. Bubble: scenario 2 with IN_VALID=0 for one cycle between rows 1 and 2. Required: OUT_VALID[i]=0 with Outputs[i]=0 for one cycle, staggered one edge per lane. FRAME_DONE is delayed by 1 cycle.
6. Reset mid-drain: SYNC_RST=0 at E4 during scenario 2. Required: everything clears and FRAME_DONE is never asserted. A new single-row frame {9,9,9,9,9} with IN_LAST=1 is accepted on the first edge after release and completes normally 4 edges later.

Source files
------------

// File: rtl/systolic_skew_buffer.sv
// rtl/systolic_skew_buffer.sv - frame-aware per-lane skew/deskew delay stage for a systolic array edge
module systolic_skew_buffer #(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 5
) (
    input  logic               CLK,
    input  logic               SYNC_RST,
    input  logic               EN,
    input  logic               MODE,
    input  logic               IN_VALID,
    input  logic               IN_LAST,
    output logic               IN_READY,
    input  logic [WIDTH-1:0]   Inputs  [0:LENGTH-1],
    output logic [WIDTH-1:0]   Outputs [0:LENGTH-1],
    output logic [LENGTH-1:0]  OUT_VALID,
    output logic               BUSY,
    output logic               FRAME_DONE
);

    localparam int CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int NS = (LENGTH > 1) ? LENGTH - 1 : 1;

    localparam logic [CW-1:0] DRAIN_LOAD = CW'(LENGTH - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_mode;
    logic          r_frame_done;
    logic          w_accept;
    logic          w_mode;

    assign IN_READY   = SYNC_RST & EN & (r_state != S_DRAIN);
    assign w_accept   = IN_VALID & IN_READY;
    assign BUSY       = (r_state != S_IDLE);
    assign FRAME_DONE = r_frame_done;

    // The first row of a frame must already use the incoming MODE; lanes are empty in IDLE.
    assign w_mode = (r_state == S_IDLE) ? MODE : r_mode;

    always_ff @(posedge CLK) begin
        if (!SYNC_RST) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_mode       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (EN) begin
                case (r_state)
                    S_IDLE, S_STREAM: begin
                        if (w_accept) begin
                            if (r_state == S_IDLE) begin
                                r_mode <= MODE;
                            end
                            if (!IN_LAST) begin
                                r_state <= S_STREAM;
                            end else if (LENGTH == 1) begin
                                r_state      <= S_IDLE;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_state <= S_DRAIN;
                                r_cnt   <= DRAIN_LOAD;
                            end
                        end
                    end
                    S_DRAIN: begin
                        r_cnt <= r_cnt - CNT_ONE;
                        if (r_cnt == CNT_ONE) begin
                            r_state      <= S_IDLE;
                            r_frame_done <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    for (genvar g = 0; g < LENGTH; g++) begin : g_lane
        localparam logic [CW-1:0] D_SKEW   = CW'(g);
        localparam logic [CW-1:0] D_DESKEW = CW'(LENGTH - 1 - g);

        logic [WIDTH-1:0] r_data [0:NS-1];
        logic [NS-1:0]    r_vld;
        logic [WIDTH-1:0] r_out;
        logic             r_out_vld;
        logic [WIDTH-1:0] w_in_data;
        logic             w_in_vld;
        logic [WIDTH-1:0] w_tap_data;
        logic             w_tap_vld;
        logic [CW-1:0]    w_delay;

        assign w_in_data = w_accept ? Inputs[g] : '0;
        assign w_in_vld  = w_accept;
        assign w_delay   = w_mode ? D_DESKEW : D_SKEW;

        // Tap d feeds the output register, so a delay of d costs d shift stages plus the output.
        always_comb begin
            w_tap_data = w_in_data;
            w_tap_vld  = w_in_vld;
            for (int j = 0; j < NS; j++) begin
                if (w_delay == CW'(j + 1)) begin
                    w_tap_data = r_data[j];
                    w_tap_vld  = r_vld[j];
                end
            end
        end

        always_ff @(posedge CLK) begin
            if (!SYNC_RST) begin
                for (int j = 0; j < NS; j++) begin
                    r_data[j] <= '0;
                end
                r_vld     <= '0;
                r_out     <= '0;
                r_out_vld <= 1'b0;
            end else if (EN) begin
                r_data[0] <= w_in_data;
                r_vld[0]  <= w_in_vld;
                for (int j = 1; j < NS; j++) begin
                    r_data[j] <= r_data[j-1];
                    r_vld[j]  <= r_vld[j-1];
                end
                r_out     <= w_tap_data;
                r_out_vld <= w_tap_vld;
            end
        end

        assign Outputs[g]   = r_out;
        assign OUT_VALID[g] = r_out_vld;
    end

endmodule
